// File: rtl/bp_cache_req_arbiter_if.sv
// Request bus between the I$/D$ miss paths and the merged LCE-side request port.
// slave is the arbiter side; master is the cache/LCE environment side.
interface bp_cache_req_arbiter_if #(
  parameter int unsigned req_width_p      = 64,
  parameter int unsigned metadata_width_p = 4
);
  logic [req_width_p-1:0]      icache_req_i;
  logic                        icache_req_v_i;
  logic                        icache_req_ready_o;
  logic [metadata_width_p-1:0] icache_req_metadata_i;
  logic                        icache_req_metadata_v_i;
  logic                        icache_req_complete_o;

  logic [req_width_p-1:0]      dcache_req_i;
  logic                        dcache_req_v_i;
  logic                        dcache_req_ready_o;
  logic [metadata_width_p-1:0] dcache_req_metadata_i;
  logic                        dcache_req_metadata_v_i;
  logic                        dcache_req_complete_o;

  logic [req_width_p-1:0]      mem_req_o;
  logic [metadata_width_p-1:0] mem_req_metadata_o;
  logic                        mem_req_src_o;
  logic                        mem_req_v_o;
  logic                        mem_req_yumi_i;
  logic                        mem_req_complete_i;

  modport slave (
    input  icache_req_i, icache_req_v_i, icache_req_metadata_i, icache_req_metadata_v_i,
    output icache_req_ready_o, icache_req_complete_o,
    input  dcache_req_i, dcache_req_v_i, dcache_req_metadata_i, dcache_req_metadata_v_i,
    output dcache_req_ready_o, dcache_req_complete_o,
    output mem_req_o, mem_req_metadata_o, mem_req_src_o, mem_req_v_o,
    input  mem_req_yumi_i, mem_req_complete_i
  );

  modport master (
    output icache_req_i, icache_req_v_i, icache_req_metadata_i, icache_req_metadata_v_i,
    input  icache_req_ready_o, icache_req_complete_o,
    output dcache_req_i, dcache_req_v_i, dcache_req_metadata_i, dcache_req_metadata_v_i,
    input  dcache_req_ready_o, dcache_req_complete_o,
    input  mem_req_o, mem_req_metadata_o, mem_req_src_o, mem_req_v_o,
    output mem_req_yumi_i, mem_req_complete_i
  );
endinterface

// File: rtl/bp_cache_req_arbiter.sv
// Round-robin arbiter merging I$ and D$ miss requests into a single outstanding
// LCE request; metadata may trail the packet and completion is returned to the source.
module bp_cache_req_arbiter #(
  parameter int unsigned req_width_p      = 64,
  parameter int unsigned metadata_width_p = 4
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  bp_cache_req_arbiter_if.slave bus
);

  typedef enum logic [1:0] {e_ready, e_wait_meta, e_send, e_wait_complete} state_e;

  state_e                      state_r;
  logic                        rr_r;
  logic                        src_r;
  logic [req_width_p-1:0]      req_r;
  logic [metadata_width_p-1:0] meta_r;
  logic                        icomplete_r;
  logic                        dcomplete_r;

  logic                        in_ready;
  logic                        icache_ready;
  logic                        dcache_ready;
  logic                        icache_hs;
  logic                        dcache_hs;
  logic                        grant_meta_v;
  logic [metadata_width_p-1:0] grant_meta;
  logic                        src_meta_v;
  logic [metadata_width_p-1:0] src_meta;

  // A source loses only when the other is also valid and holds priority.
  assign in_ready     = (state_r == e_ready);
  assign icache_ready = in_ready & (~bus.dcache_req_v_i | ~rr_r);
  assign dcache_ready = in_ready & (~bus.icache_req_v_i | rr_r);
  assign icache_hs    = bus.icache_req_v_i & icache_ready;
  assign dcache_hs    = bus.dcache_req_v_i & dcache_ready;

  assign grant_meta_v = dcache_hs ? bus.dcache_req_metadata_v_i : bus.icache_req_metadata_v_i;
  assign grant_meta   = dcache_hs ? bus.dcache_req_metadata_i   : bus.icache_req_metadata_i;
  assign src_meta_v   = src_r     ? bus.dcache_req_metadata_v_i : bus.icache_req_metadata_v_i;
  assign src_meta     = src_r     ? bus.dcache_req_metadata_i   : bus.icache_req_metadata_i;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r     <= e_ready;
      rr_r        <= 1'b0;
      src_r       <= 1'b0;
      req_r       <= '0;
      meta_r      <= '0;
      icomplete_r <= 1'b0;
      dcomplete_r <= 1'b0;
    end else begin
      icomplete_r <= 1'b0;
      dcomplete_r <= 1'b0;
      unique case (state_r)
        e_ready: begin
          if (icache_hs | dcache_hs) begin
            req_r <= dcache_hs ? bus.dcache_req_i : bus.icache_req_i;
            src_r <= dcache_hs;
            if (grant_meta_v) begin
              meta_r  <= grant_meta;
              state_r <= e_send;
            end else begin
              state_r <= e_wait_meta;
            end
          end
        end
        e_wait_meta: begin
          if (src_meta_v) begin
            meta_r  <= src_meta;
            state_r <= e_send;
          end
        end
        e_send: begin
          if (bus.mem_req_yumi_i) begin
            rr_r    <= ~src_r;
            state_r <= e_wait_complete;
          end
        end
        e_wait_complete: begin
          if (bus.mem_req_complete_i) begin
            icomplete_r <= ~src_r;
            dcomplete_r <= src_r;
            state_r     <= e_ready;
          end
        end
        default: state_r <= e_ready;
      endcase
    end
  end

  assign bus.icache_req_ready_o    = icache_ready;
  assign bus.dcache_req_ready_o    = dcache_ready;
  assign bus.icache_req_complete_o = icomplete_r;
  assign bus.dcache_req_complete_o = dcomplete_r;
  assign bus.mem_req_v_o           = (state_r == e_send);
  assign bus.mem_req_o             = req_r;
  assign bus.mem_req_metadata_o    = meta_r;
  assign bus.mem_req_src_o         = src_r;

endmodule

// File: tb/tb_bp_cache_req_arbiter.sv
// Bench for bp_cache_req_arbiter: directed cycle table, D$-only streaming run,
// then random traffic checked against a transaction-level reference model.
module tb_bp_cache_req_arbiter;
  localparam int unsigned RW = 64;
  localparam int unsigned MW = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  bp_cache_req_arbiter_if #(.req_width_p(RW), .metadata_width_p(MW)) bus ();

  bp_cache_req_arbiter #(.req_width_p(RW), .metadata_width_p(MW)) dut (
    .clk_i  (clk),
    .reset_i(reset),
    .bus    (bus.slave)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one outstanding transaction record plus the rr priority bit.
  bit          m_busy = 0, m_src = 0, m_meta_ok = 0, m_sent = 0, m_rr = 0;
  bit          m_ci = 0, m_cd = 0;
  logic [63:0] m_pkt = '0;
  logic [3:0]  m_meta = '0;

  always @(posedge clk) begin : ref_model
    bit g_i, g_d;
    g_i = !m_busy && bus.icache_req_v_i && (!bus.dcache_req_v_i || !m_rr);
    g_d = !m_busy && bus.dcache_req_v_i && (!bus.icache_req_v_i || m_rr);
    if (reset) begin
      m_busy = 0; m_rr = 0; m_ci = 0; m_cd = 0; m_meta_ok = 0; m_sent = 0; m_src = 0;
    end else begin
      m_ci = 0;
      m_cd = 0;
      if (g_i || g_d) begin
        m_busy    = 1;
        m_src     = g_d;
        m_sent    = 0;
        m_pkt     = g_d ? bus.dcache_req_i : bus.icache_req_i;
        m_meta_ok = g_d ? bus.dcache_req_metadata_v_i : bus.icache_req_metadata_v_i;
        m_meta    = g_d ? bus.dcache_req_metadata_i : bus.icache_req_metadata_i;
      end else if (m_busy && !m_meta_ok) begin
        if (m_src ? bus.dcache_req_metadata_v_i : bus.icache_req_metadata_v_i) begin
          m_meta_ok = 1;
          m_meta    = m_src ? bus.dcache_req_metadata_i : bus.icache_req_metadata_i;
        end
      end else if (m_busy && !m_sent) begin
        if (bus.mem_req_yumi_i) begin
          m_sent = 1;
          m_rr   = !m_src;
        end
      end else if (m_busy) begin
        if (bus.mem_req_complete_i) begin
          m_busy = 0;
          if (m_src) m_cd = 1;
          else m_ci = 1;
        end
      end
    end
  end

  task automatic drive(input bit rst, input bit iv, input bit dv, input bit imv, input bit dmv,
                       input bit yumi, input bit cmp, input logic [63:0] ip, input logic [63:0] dp,
                       input logic [3:0] im, input logic [3:0] dm);
    @(negedge clk);
    reset                       = rst;
    bus.icache_req_v_i          = iv;
    bus.dcache_req_v_i          = dv;
    bus.icache_req_metadata_v_i = imv;
    bus.dcache_req_metadata_v_i = dmv;
    bus.mem_req_yumi_i          = yumi;
    bus.mem_req_complete_i      = cmp;
    bus.icache_req_i            = ip;
    bus.dcache_req_i            = dp;
    bus.icache_req_metadata_i   = im;
    bus.dcache_req_metadata_i   = dm;
    #1;
  endtask

  task automatic check_model();
    bit exp_mv;
    exp_mv = m_busy && m_meta_ok && !m_sent;
    check("m_iready", bus.icache_req_ready_o,
          !m_busy && (!bus.dcache_req_v_i || !m_rr));
    check("m_dready", bus.dcache_req_ready_o,
          !m_busy && (!bus.icache_req_v_i || m_rr));
    check("m_mem_v", bus.mem_req_v_o, exp_mv);
    check("m_icmpl", bus.icache_req_complete_o, m_ci);
    check("m_dcmpl", bus.dcache_req_complete_o, m_cd);
    if (exp_mv) begin
      check("m_src", bus.mem_req_src_o, m_src);
      check("m_pkt", bus.mem_req_o, m_pkt);
      check("m_meta", bus.mem_req_metadata_o, m_meta);
    end
  endtask

  typedef struct {
    bit rst, iv, dv, imv, dmv, yumi, cmp;
    logic [63:0] dp;
    logic [3:0] im, dm;
    bit chk, ri, rd, mv, src, ci, cd;
    logic [63:0] pkt;
    logic [3:0] meta;
  } vec_t;

  function automatic vec_t v(bit rst, bit iv, bit dv, bit imv, bit dmv, bit yumi, bit cmp,
                             logic [63:0] dp, logic [3:0] im, logic [3:0] dm, bit chk, bit ri,
                             bit rd, bit mv, bit src, bit ci, bit cd, logic [63:0] pkt,
                             logic [3:0] meta);
    vec_t r;
    r.rst = rst; r.iv = iv; r.dv = dv; r.imv = imv; r.dmv = dmv; r.yumi = yumi; r.cmp = cmp;
    r.dp = dp; r.im = im; r.dm = dm; r.chk = chk; r.ri = ri; r.rd = rd; r.mv = mv;
    r.src = src; r.ci = ci; r.cd = cd; r.pkt = pkt; r.meta = meta;
    return r;
  endfunction

  localparam logic [63:0] IP = 64'hA;
  localparam logic [63:0] DP = 64'hB;
  localparam logic [63:0] DB = 64'hDEAD_BEEF;

  vec_t tbl[21];

  initial begin
    int accepted, sent, done;
    //            rst iv dv im dm yu cp  dp  im    dm   chk ri rd mv sr ci cd pkt meta
    tbl[0]  = v(1, 0, 0, 0, 0, 0, 0, DP, 4'h3, 4'h6, 0, 0, 0, 0, 0, 0, 0, 0,  0);
    tbl[1]  = v(0, 0, 0, 0, 0, 0, 0, DP, 4'h3, 4'h6, 1, 1, 1, 0, 0, 0, 0, 0,  0);
    tbl[2]  = v(0, 1, 1, 1, 1, 0, 0, DP, 4'h3, 4'h6, 1, 1, 0, 0, 0, 0, 0, 0,  0);
    tbl[3]  = v(0, 0, 1, 0, 0, 0, 0, DP, 4'h3, 4'h6, 1, 0, 0, 1, 0, 0, 0, IP, 3);
    tbl[4]  = v(0, 0, 1, 0, 0, 1, 0, DP, 4'h3, 4'h6, 1, 0, 0, 1, 0, 0, 0, IP, 3);
    tbl[5]  = v(0, 0, 1, 0, 0, 0, 1, DP, 4'h3, 4'h6, 1, 0, 0, 0, 0, 0, 0, 0,  0);
    tbl[6]  = v(0, 1, 1, 0, 1, 0, 0, DP, 4'h3, 4'h6, 1, 0, 1, 0, 0, 1, 0, 0,  0);
    tbl[7]  = v(0, 0, 0, 0, 0, 0, 1, DP, 4'h3, 4'h6, 1, 0, 0, 1, 1, 0, 0, DP, 6);
    tbl[8]  = v(0, 0, 0, 0, 0, 1, 0, DP, 4'h3, 4'h6, 1, 0, 0, 1, 1, 0, 0, DP, 6);
    tbl[9]  = v(1, 0, 0, 0, 0, 0, 0, DP, 4'h3, 4'h6, 1, 0, 0, 0, 0, 0, 0, 0,  0);
    tbl[10] = v(0, 0, 0, 0, 0, 0, 1, DP, 4'h3, 4'h6, 1, 1, 1, 0, 0, 0, 0, 0,  0);
    tbl[11] = v(0, 0, 0, 0, 0, 0, 0, DP, 4'h3, 4'h6, 1, 1, 1, 0, 0, 0, 0, 0,  0);
    tbl[12] = v(0, 0, 1, 0, 0, 0, 0, DB, 4'h3, 4'h6, 1, 1, 1, 0, 0, 0, 0, 0,  0);
    tbl[13] = v(0, 0, 0, 1, 0, 0, 0, DP, 4'hF, 4'h6, 1, 0, 0, 0, 0, 0, 0, 0,  0);
    tbl[14] = v(0, 0, 0, 0, 1, 0, 0, DP, 4'h3, 4'h5, 1, 0, 0, 0, 0, 0, 0, 0,  0);
    tbl[15] = v(0, 0, 0, 0, 0, 0, 0, DP, 4'h3, 4'h6, 1, 0, 0, 1, 1, 0, 0, DB, 5);
    tbl[16] = v(0, 0, 0, 0, 0, 0, 0, DP, 4'h3, 4'h6, 1, 0, 0, 1, 1, 0, 0, DB, 5);
    tbl[17] = v(0, 0, 0, 0, 1, 0, 0, DP, 4'h3, 4'h9, 1, 0, 0, 1, 1, 0, 0, DB, 5);
    tbl[18] = v(0, 0, 0, 0, 0, 1, 0, DP, 4'h3, 4'h6, 1, 0, 0, 1, 1, 0, 0, DB, 5);
    tbl[19] = v(0, 0, 0, 0, 0, 0, 1, DP, 4'h3, 4'h6, 1, 0, 0, 0, 0, 0, 0, 0,  0);
    tbl[20] = v(0, 0, 0, 0, 0, 0, 0, DP, 4'h3, 4'h6, 1, 1, 1, 0, 0, 0, 1, 0,  0);

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].iv, tbl[i].dv, tbl[i].imv, tbl[i].dmv, tbl[i].yumi, tbl[i].cmp,
            IP, tbl[i].dp, tbl[i].im, tbl[i].dm);
      if (tbl[i].chk) begin
        check($sformatf("t%0d_iready", i), bus.icache_req_ready_o, tbl[i].ri);
        check($sformatf("t%0d_dready", i), bus.dcache_req_ready_o, tbl[i].rd);
        check($sformatf("t%0d_mem_v", i), bus.mem_req_v_o, tbl[i].mv);
        check($sformatf("t%0d_icmpl", i), bus.icache_req_complete_o, tbl[i].ci);
        check($sformatf("t%0d_dcmpl", i), bus.dcache_req_complete_o, tbl[i].cd);
        if (tbl[i].mv) begin
          check($sformatf("t%0d_src", i), bus.mem_req_src_o, tbl[i].src);
          check($sformatf("t%0d_pkt", i), bus.mem_req_o, tbl[i].pkt);
          check($sformatf("t%0d_meta", i), bus.mem_req_metadata_o, tbl[i].meta);
        end
      end
    end

    // D$-only stream with immediate yumi/complete: 16 requests, in order, bounded.
    accepted = 0;
    sent     = 0;
    done     = 0;
    for (int c = 0; c < 200 && done < 16; c++) begin
      drive(0, 0, accepted < 16, 0, 1, 1, 1, IP, 64'h1000 + 64'(accepted), 4'h0,
            4'(accepted));
      check_model();
      if (bus.mem_req_v_o) begin
        check("stream_order", bus.mem_req_o, 64'h1000 + 64'(sent));
        sent++;
      end
      if (bus.dcache_req_complete_o) done++;
      if (bus.dcache_req_ready_o && accepted < 16) accepted++;
    end
    check("stream_done", 64'(done), 64'd16);
    check("stream_sent", 64'(sent), 64'd16);

    // Random traffic against the reference model.
    for (int c = 0; c < 3000; c++) begin
      drive($urandom_range(0, 99) == 0, $urandom_range(0, 1), $urandom_range(0, 1),
            $urandom_range(0, 9) < 4, $urandom_range(0, 9) < 4, $urandom_range(0, 1),
            $urandom_range(0, 9) < 4, {$urandom, $urandom}, {$urandom, $urandom},
            4'($urandom), 4'($urandom));
      check_model();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
